// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and helpers for the sequential multiplier
//
// Purpose: state encoding and magnitude/negate helpers for mult_seq.
// The helpers work on a wide MAX_W container; callers sign- or zero-extend
// into it and truncate the result back to their own width with a size cast.
// No ports (package).
package mult_pkg;

  typedef enum logic [1:0] {IDLE, LOOP, DONE} mult_state_t;

  // Widest container the helpers handle; covers P_WIDTH up to 128.
  localparam int MAX_W = 128;

  // Magnitude of a sign-extended operand. -2^(W-1) maps to 2^(W-1), which
  // still fits the operand's own width once truncated as unsigned.
  function automatic logic [MAX_W-1:0] abs_u(input logic [MAX_W-1:0] x);
    return x[MAX_W-1] ? (~x + MAX_W'(1)) : x;
  endfunction

  // Two's-complement negate; the caller truncates to P_WIDTH.
  function automatic logic [MAX_W-1:0] neg_p(input logic [MAX_W-1:0] x);
    return ~x + MAX_W'(1);
  endfunction

endpackage

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - sequential signed shift-add multiplier
//
// Purpose: multiplies two signed operands one multiplier bit per cycle on
// the operand magnitudes, then applies the sign once at the end.
// Optional feature macro: MULT_EARLY_EXIT_EN (leave the loop as soon as the
// remaining multiplier bits are all zero).
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high
//   valid_in   in   operands valid
//   in_ready   out  high only while idle
//   a          in   A_WIDTH signed multiplicand
//   b          in   B_WIDTH signed multiplier
//   product    out  P_WIDTH signed product, registered, held after consume
//   valid_out  out  product valid, held until out_ready
//   out_ready  in   downstream accepts product
module mult_seq
  import mult_pkg::*;
#(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_in,
  output logic                       in_ready,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  output logic [A_WIDTH+B_WIDTH-1:0] product,
  output logic                       valid_out,
  input  logic                       out_ready
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;
  localparam int CNT_W   = (B_WIDTH > 1) ? $clog2(B_WIDTH) : 1;

  mult_state_t        state_q, state_d;
  logic [P_WIDTH-1:0] ma_q, ma_d;
  logic [B_WIDTH-1:0] mb_q, mb_d;
  logic [P_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic [P_WIDTH-1:0] product_q, product_d;
  logic               valid_out_q, valid_out_d;
  logic               in_ready_q, in_ready_d;

  logic [P_WIDTH-1:0] acc_sum;
  logic [B_WIDTH-1:0] mb_shift;
  logic [A_WIDTH-1:0] abs_a;
  logic [B_WIDTH-1:0] abs_b;
  logic               loop_exit;

  always_comb begin
    state_d     = state_q;
    ma_d        = ma_q;
    mb_d        = mb_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    product_d   = product_q;
    valid_out_d = valid_out_q;
    in_ready_d  = in_ready_q;

    abs_a    = A_WIDTH'(abs_u(MAX_W'($signed(a))));
    abs_b    = B_WIDTH'(abs_u(MAX_W'($signed(b))));
    // The final iteration's partial product is folded in here so the
    // LOOP->DONE edge can load the finished result directly.
    acc_sum  = acc_q + (mb_q[0] ? ma_q : '0);
    mb_shift = mb_q >> 1;
`ifdef MULT_EARLY_EXIT_EN
    loop_exit = (cnt_q == CNT_W'(B_WIDTH - 1)) || (mb_shift == '0);
`else
    loop_exit = (cnt_q == CNT_W'(B_WIDTH - 1));
`endif

    case (state_q)
      IDLE: begin
        if (valid_in && in_ready_q) begin
          ma_d       = P_WIDTH'(abs_a);
          mb_d       = abs_b;
          sign_d     = a[A_WIDTH-1] ^ b[B_WIDTH-1];
          acc_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = LOOP;
        end
      end
      LOOP: begin
        acc_d = acc_sum;
        ma_d  = ma_q << 1;
        mb_d  = mb_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (loop_exit) begin
          // A zero magnitude is never negated, so a zero result is never -0.
          product_d   = (sign_q && (acc_sum != '0))
                        ? P_WIDTH'(neg_p(MAX_W'(acc_sum))) : acc_sum;
          valid_out_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          valid_out_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        valid_out_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ma_q        <= '0;
      mb_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      product_q   <= '0;
      valid_out_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      product_q   <= product_d;
      valid_out_q <= valid_out_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign product   = product_q;
  assign valid_out = valid_out_q;
  assign in_ready  = in_ready_q;

endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - self-checking bench for mult_seq
module tb_mult_seq;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] product;
  logic        valid_out;
  logic        out_ready;

  int vectors;
  int miscompares;

  mult_seq #(.A_WIDTH(32), .B_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .product   (product),
    .valid_out (valid_out),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level reference: an accepted operation yields the signed
  // product after a latency given by the multiplier magnitude, and the
  // block is busy from accept until the result is consumed.
  logic        m_busy;
  logic        m_valid;
  logic [63:0] m_prod;
  logic [63:0] m_pending;
  int          m_count;

  function automatic int exp_latency(input logic [31:0] bv);
    longint mag;
    int     lat;
    mag = longint'($signed(bv));
    if (mag < 0) mag = -mag;
`ifdef MULT_EARLY_EXIT_EN
    lat = 1;
    for (int i = 0; i < 32; i++) if (mag[i]) lat = i + 1;
`else
    lat = 32;
`endif
    return lat;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_prod  <= '0;
      m_count <= 0;
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid <= 1'b0;
        m_busy  <= 1'b0;
      end
    end else if (m_busy) begin
      if (m_count == 1) begin
        m_valid <= 1'b1;
        m_prod  <= m_pending;
      end
      m_count <= m_count - 1;
    end else if (valid_in) begin
      m_busy    <= 1'b1;
      m_pending <= 64'(longint'($signed(a)) * longint'($signed(b)));
      m_count   <= exp_latency(b);
    end
  end

  bit checking;

  always @(negedge clk) begin
    if (checking && !reset) begin
      vectors++;
      if (in_ready !== !m_busy) begin
        miscompares++;
        $display("FAIL in_ready: got %b expected %b at %0t", in_ready, !m_busy, $time);
      end
      vectors++;
      if (valid_out !== m_valid) begin
        miscompares++;
        $display("FAIL valid_out: got %b expected %b at %0t", valid_out, m_valid, $time);
      end
      vectors++;
      if (product !== m_prod) begin
        miscompares++;
        $display("FAIL product: got %h expected %h at %0t", product, m_prod, $time);
      end
    end
  end

  task automatic check_lit(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_in_ready();
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      miscompares++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv,
                        input logic [63:0] lit, input int hold);
    int n;
    wait_in_ready();
    a = ta; b = tbv; valid_in = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    valid_in = 1'b0;
    a = $urandom; b = $urandom;
    n = 0;
    while (!valid_out && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (!valid_out) begin
      miscompares++;
      $display("FAIL valid_out_timeout: got 0 expected 1");
    end
    check_lit("product_literal", product, lit);
    if (hold > 0) begin
      // Stray operands during backpressure must be ignored.
      valid_in = 1'b1; a = 32'd1; b = 32'd1;
      @(posedge clk); #1;
      valid_in = 1'b0;
      repeat (hold - 1) begin
        @(posedge clk); #1;
      end
      check_lit("held_product", product, lit);
      check_lit("held_valid", 64'(valid_out), 64'd1);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] va   [9] = '{32'd7, -32'sd5, 32'd5, -32'sd5, 32'h8000_0000,
                            32'h8000_0000, -32'sd9, 32'h7FFF_FFFF, 32'd1234};
  logic [31:0] vb   [9] = '{32'd6, 32'd3, -32'sd3, -32'sd3, 32'h8000_0000,
                            32'd1, 32'd0, 32'h7FFF_FFFF, -32'sd567};
  logic [63:0] vp   [9] = '{64'd42, 64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFF1,
                            64'd15, 64'h4000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000,
                            64'd0, 64'h3FFF_FFFF_0000_0001, 64'hFFFF_FFFF_FFF5_52E2};
  int          vhold[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 10};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0; miscompares = 0; checking = 1'b0;
    reset = 1'b1; valid_in = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_lit("reset_product", product, 64'd0);
    check_lit("reset_valid_out", 64'(valid_out), 64'd0);
    check_lit("reset_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;
    checking = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_op(va[i], vb[i], vp[i], vhold[i]);

    // Abort an operation five cycles into the loop.
    wait_in_ready();
    a = 32'd100; b = 32'd77; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #2;
    check_lit("abort_valid_out", 64'(valid_out), 64'd0);
    check_lit("abort_product", product, 64'd0);
    check_lit("abort_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_op(32'd3, 32'd4, 64'd12, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    checking = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
